strided_access_scheduler: RTL and testbench
===========================================

# strided_access_scheduler

Arbitrates strided memory-access descriptors from two requesters onto a single strided memory port, like the CADA memory test wrapper's addrIn/count/stride/writeEn/valid ports. Each requester queues descriptors (start address, beat count, stride, write flag) in a private 2-deep FIFO. A round-robin scheduler picks one descriptor at a time and expands it into per-beat address/write-enable/valid beats under memory backpressure. When a descriptor finishes, the scheduler pulses a per-requester done signal.

## Interface
- AW, 5, address width; addresses wrap modulo 2^AW
- CW, 8, beat-count width
- SW, 4, stride width (unsigned)

- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- req_valid  in  2  descriptor offered, bit i = requester i
- req_ready  out  2  bit i = requester i FIFO not full
- req_addr  in  2*AW  start address, requester i at [i*AW +: AW]
- req_count  in  2*CW  beat count per requester
- req_stride  in  2*SW  address increment per beat
- req_wen  in  2  write (1) / read (0) per requester
- mem_valid  out  1  beat present on mem_addr/mem_wen
- mem_ready  in  1  memory accepts beat
- mem_addr  out  AW  beat address
- mem_wen  out  1  beat write enable, forced 0 when mem_valid=0
- mem_rid  out  1  requester owning current beat
- done  out  2  one-cycle pulse when requester i's descriptor retires
- busy  out  1  FSM not IDLE or any FIFO non-empty

## Operation
- **Enqueue:** descriptor i is written to FIFO i when req_valid[i] && req_ready[i]. req_ready[i] = !full_i and does not depend on req_valid. Each FIFO is 2 deep and FIFO ordered. Both requesters may enqueue in the same cycle.
- **FSM states:** IDLE and BURST.
- **IDLE → selection:** if any FIFO is non-empty, grant by round-robin.
  - If only one FIFO is non-empty, grant it.
  - If both are non-empty, grant the requester not granted last. The last-grant pointer resets to 1, so requester 0 wins the first tie.
  - Pop the granted descriptor. Load cur_addr=addr, remaining=count, stride, wen, rid.
- **IDLE with count=0:** the descriptor is popped and pulses done[rid] in the next cycle. No beat is issued, the FSM stays in IDLE, and the pointer still updates.
- **IDLE with count≠0:** go to BURST.
- **BURST:**
  - mem_valid=1, mem_addr=cur_addr, mem_wen=wen, mem_rid=rid.
  - On mem_valid && mem_ready: cur_addr ← (cur_addr+stride) mod 2^AW and remaining ← remaining−1.
  - If remaining was 1: go to IDLE and assert done[rid] in the following cycle.
  - Without mem_ready, all beat outputs hold stable.
- **Arithmetic:** the address add truncates to AW bits. count uses the full CW range, so max 2^CW−1 beats.
- **No preemption:** a descriptor always completes before any re-arbitration.
- **Reset (asserted at any time, including mid-burst):**
  - FIFOs empty, FSM to IDLE, counters cleared, pointer=1.
  - Outputs: mem_valid=0, mem_addr=0, mem_wen=0, mem_rid=0, done=0, busy=0, req_ready=2'b11 once rst is deasserted.
  - The in-flight burst is discarded with no done pulse.

## Timing
- **Start latency:** descriptor accepted in cycle c → first mem_valid in cycle c+2 (FIFO write at end of c, grant at end of c+1). This holds only if the FSM is in IDLE in cycle c+1, i.e. idle, not busy with another burst.
- **Throughput:** one beat per cycle while mem_ready=1. An N-beat descriptor occupies N cycles of mem_valid.
- **Retirement:** done[rid] is high in the cycle after the last beat handshake, for exactly one cycle.
- **Inter-descriptor gap:** one IDLE bubble cycle between bursts, so the next mem_valid appears 2 cycles after the last handshake.
- **FIFO pop:** a pop frees its slot, and req_ready rises in the cycle after the pop.

## Test plan
- **Single write burst:** after reset, req0 {addr=0, count=3, stride=1, wen=1} → beats at addr 0,1,2 with mem_wen=1 and rid=0 in cycles c+2..c+4. done[0] pulses in c+5. busy falls after the pulse.
- **Wrap plus backpressure:** req1 {addr=30, count=4, stride=3, wen=0}, mem_ready low in alternate cycles → addrs 30,1,4,7. Each beat holds until accepted. mem_wen=0 throughout. Exactly one done[1].
- **Round-robin on tie:** both requesters enqueue two descriptors (count=2) in the same cycle → grant order 0,1,0,1 with one bubble cycle between bursts. req_ready drops to 0 while both FIFOs are full.
- **Zero count:** req0 count=0 followed by req0 count=1, addr=5 → done[0] pulses with no mem_valid, then a single beat at addr 5 and a second done[0].
- **Reset mid-burst:** rst low during beat 2 of a count=8 burst → mem_valid=0 immediately (asynchronous), FIFOs empty, no done pulse. A new descriptor after release starts cleanly with requester 0 winning the first tie.

Source files
------------

// File: rtl/strided_access_scheduler.sv
// strided_access_scheduler: round-robin arbiter of two requesters' strided descriptors
// onto one memory beat port, with a 2-deep descriptor FIFO per requester.
module strided_access_scheduler #(
  parameter int AW = 5,
  parameter int CW = 8,
  parameter int SW = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      req_valid,
  output logic [1:0]      req_ready,
  input  logic [2*AW-1:0] req_addr,
  input  logic [2*CW-1:0] req_count,
  input  logic [2*SW-1:0] req_stride,
  input  logic [1:0]      req_wen,
  output logic            mem_valid,
  input  logic            mem_ready,
  output logic [AW-1:0]   mem_addr,
  output logic            mem_wen,
  output logic            mem_rid,
  output logic [1:0]      done,
  output logic            busy
);
  localparam int DW = AW + CW + SW + 1;
  typedef enum logic {IDLE, BURST} state_t;
  state_t        state_q, state_d;
  logic [DW-1:0] fifo_q [2][2];
  logic [DW-1:0] fifo_d [2][2];
  logic          wp_q [2];
  logic          wp_d [2];
  logic          rp_q [2];
  logic          rp_d [2];
  logic [1:0]    cnt_q [2];
  logic [1:0]    cnt_d [2];
  logic [AW-1:0] cur_addr_q, cur_addr_d;
  logic [CW-1:0] rem_q, rem_d;
  logic [SW-1:0] stride_q, stride_d;
  logic          wen_q, wen_d, rid_q, rid_d, last_q, last_d;
  logic [1:0]    done_q, done_d, ne, push, pop;
  logic          grant;
  logic [DW-1:0] head;
  logic [CW-1:0] head_count;

  always_comb begin
    ne = '0;
    req_ready = '0;
    push = '0;
    for (int i = 0; i < 2; i++) begin
      ne[i] = cnt_q[i] != 2'd0;
      req_ready[i] = cnt_q[i] != 2'd2;
      push[i] = req_valid[i] && req_ready[i];
    end
  end

  // On a tie the requester that did not win last time gets the grant
  assign grant = (&ne) ? ~last_q : ne[1];
  assign head = fifo_q[grant][rp_q[grant]];
  assign head_count = head[SW+1 +: CW];

  always_comb begin
    state_d = state_q;
    cur_addr_d = cur_addr_q;
    rem_d = rem_q;
    stride_d = stride_q;
    wen_d = wen_q;
    rid_d = rid_q;
    last_d = last_q;
    done_d = '0;
    pop = '0;
    if (state_q == IDLE) begin
      if (|ne) begin
        pop[grant] = 1'b1;
        last_d = grant;
        rid_d = grant;
        {cur_addr_d, rem_d, stride_d, wen_d} = head;
        done_d[grant] = head_count == '0;
        state_d = (head_count == '0) ? IDLE : BURST;
      end
    end else if (mem_ready) begin
      cur_addr_d = cur_addr_q + AW'(stride_q);
      rem_d = rem_q - 1'b1;
      if (rem_q == CW'(1)) begin
        state_d = IDLE;
        done_d[rid_q] = 1'b1;
      end
    end
  end

  always_comb begin
    fifo_d = fifo_q;
    for (int i = 0; i < 2; i++) begin
      wp_d[i] = wp_q[i] ^ push[i];
      rp_d[i] = rp_q[i] ^ pop[i];
      cnt_d[i] = cnt_q[i] + 2'(push[i]) - 2'(pop[i]);
      if (push[i])
        fifo_d[i][wp_q[i]] = {req_addr[i*AW +: AW], req_count[i*CW +: CW],
                              req_stride[i*SW +: SW], req_wen[i]};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      fifo_q <= '{default: '0};
      wp_q <= '{default: 1'b0};
      rp_q <= '{default: 1'b0};
      cnt_q <= '{default: 2'd0};
      cur_addr_q <= '0;
      rem_q <= '0;
      stride_q <= '0;
      wen_q <= 1'b0;
      rid_q <= 1'b0;
      last_q <= 1'b1;
      done_q <= '0;
    end else begin
      state_q <= state_d;
      fifo_q <= fifo_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
      cur_addr_q <= cur_addr_d;
      rem_q <= rem_d;
      stride_q <= stride_d;
      wen_q <= wen_d;
      rid_q <= rid_d;
      last_q <= last_d;
      done_q <= done_d;
    end
  end

  assign mem_valid = state_q == BURST;
  assign mem_addr = cur_addr_q;
  assign mem_wen = mem_valid & wen_q;
  assign mem_rid = rid_q;
  assign done = done_q;
  assign busy = mem_valid || (|ne);
endmodule

// File: tb/tb_strided_access_scheduler.sv
// tb_strided_access_scheduler: directed and random stimulus checked cycle by cycle against
// a queue-based descriptor model of the scheduler.
module tb_strided_access_scheduler;
  localparam int AW = 5, CW = 8, SW = 4;
  logic            clk = 1'b0, rst = 1'b0;
  logic [1:0]      req_valid = '0, req_wen = '0, req_ready, done;
  logic [2*AW-1:0] req_addr = '0;
  logic [2*CW-1:0] req_count = '0;
  logic [2*SW-1:0] req_stride = '0;
  logic            mem_valid, mem_ready = 1'b0, mem_wen, mem_rid, busy;
  logic [AW-1:0]   mem_addr;

  always #5 clk = ~clk;

  strided_access_scheduler #(.AW(AW), .CW(CW), .SW(SW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_count(req_count), .req_stride(req_stride), .req_wen(req_wen),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wen(mem_wen),
    .mem_rid(mem_rid), .done(done), .busy(busy)
  );

  typedef struct packed {logic [AW-1:0] a; logic [CW-1:0] c; logic [SW-1:0] s; logic w;} desc_t;
  desc_t         mq0[$], mq1[$];
  logic          m_burst, m_wen, m_rid, m_last;
  logic [AW-1:0] m_addr;
  logic [SW-1:0] m_stride;
  int            m_rem;
  logic [1:0]    m_done;
  int            cyc = 0, checks = 0, errors = 0;
  int            beat_cyc[$], done_cyc[$];
  logic [AW-1:0] beat_addr[$];
  logic          beat_rid[$], beat_wen[$];
  logic [1:0]    done_val[$];

  task automatic model_reset();
    mq0.delete(); mq1.delete();
    m_burst = 0; m_wen = 0; m_rid = 0; m_last = 1; m_addr = '0; m_stride = '0; m_rem = 0; m_done = '0;
  endtask

  task automatic clear_logs();
    beat_cyc.delete(); beat_addr.delete(); beat_rid.delete(); beat_wen.delete();
    done_cyc.delete(); done_val.delete();
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [CW-1:0] c,
                         input logic [SW-1:0] s, input logic w);
    req_valid[i] = 1'b1;
    req_addr[i*AW +: AW] = a;
    req_count[i*CW +: CW] = c;
    req_stride[i*SW +: SW] = s;
    req_wen[i] = w;
  endtask

  function automatic logic [12:0] got_out();
    return {mem_valid, mem_valid ? mem_addr : AW'(0), mem_wen, mem_valid ? mem_rid : 1'b0,
            done, req_ready, busy};
  endfunction

  function automatic logic [12:0] exp_out();
    return {m_burst, m_burst ? m_addr : AW'(0), m_burst & m_wen, m_burst & m_rid, m_done,
            mq1.size() < 2, mq0.size() < 2, m_burst || mq0.size() != 0 || mq1.size() != 0};
  endfunction

  // Advance one clock: log what the DUT shows, then apply the descriptor rules to the model
  task automatic step();
    desc_t d;
    logic [1:0] nd, acc;
    logic g;
    nd = '0;
    if (mem_valid && mem_ready) begin
      beat_cyc.push_back(cyc); beat_addr.push_back(mem_addr);
      beat_rid.push_back(mem_rid); beat_wen.push_back(mem_wen);
    end
    if (done != 2'b00) begin done_cyc.push_back(cyc); done_val.push_back(done); end
    acc = {req_valid[1] && mq1.size() < 2, req_valid[0] && mq0.size() < 2};
    if (!m_burst) begin
      if (mq0.size() != 0 || mq1.size() != 0) begin
        g = (mq0.size() != 0 && mq1.size() != 0) ? !m_last : (mq1.size() != 0);
        if (g) d = mq1.pop_front(); else d = mq0.pop_front();
        m_last = g; m_rid = g; m_addr = d.a; m_rem = int'(d.c); m_stride = d.s; m_wen = d.w;
        if (d.c == 0) nd[g] = 1'b1; else m_burst = 1;
      end
    end else if (mem_ready) begin
      m_addr = AW'((int'(m_addr) + int'(m_stride)) % (1 << AW));
      m_rem = m_rem - 1;
      if (m_rem == 0) begin m_burst = 0; nd[m_rid] = 1'b1; end
    end
    if (acc[0]) mq0.push_back({req_addr[AW-1:0], req_count[CW-1:0], req_stride[SW-1:0], req_wen[0]});
    if (acc[1]) mq1.push_back({req_addr[2*AW-1:AW], req_count[2*CW-1:CW], req_stride[2*SW-1:SW], req_wen[1]});
    @(posedge clk);
    m_done = nd;
    cyc++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({mem_valid, mem_addr, mem_wen, mem_rid, done, busy, req_ready} !== {1'b0, 5'd0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b11}) begin
      errors++;
      $display("FAIL reset_state got v=%b a=%0d w=%b r=%b d=%b b=%b rdy=%b", mem_valid, mem_addr, mem_wen, mem_rid, done, busy, req_ready);
    end
    rst = 1'b1;
    checks++;
    if (got_out() !== exp_out()) begin errors++; $display("FAIL reset_release got=%h want=%h", got_out(), exp_out()); end
  endtask

  task automatic test_single_write();
    int c;
    clear_logs();
    c = cyc; mem_ready = 1'b1;
    set_req(0, 5'd0, 8'd3, 4'd1, 1'b1);
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (got_out() !== exp_out()) begin errors++; $display("FAIL single cyc=%0d got=%h want=%h", cyc, got_out(), exp_out()); end
      step();
      req_valid = '0;
    end
    checks++;
    if (beat_cyc.size() != 3 || done_cyc.size() != 1) begin
      errors++; $display("FAIL single_counts got beats=%0d dones=%0d want 3 1", beat_cyc.size(), done_cyc.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if ({beat_cyc[k], beat_addr[k], beat_wen[k], beat_rid[k]} !== {c + 2 + k, AW'(k), 1'b1, 1'b0}) begin
          errors++; $display("FAIL single_beat%0d got cyc=%0d a=%0d w=%b r=%b", k, beat_cyc[k] - c, beat_addr[k], beat_wen[k], beat_rid[k]);
        end
      end
      checks++;
      if (done_cyc[0] != c + 5 || done_val[0] !== 2'b01) begin
        errors++; $display("FAIL single_done got cyc=c+%0d val=%b want c+5 01", done_cyc[0] - c, done_val[0]);
      end
    end
  endtask

  task automatic test_wrap_backpressure();
    logic [AW-1:0] exp_a[4] = '{5'd30, 5'd1, 5'd4, 5'd7};
    clear_logs();
    set_req(1, 5'd30, 8'd4, 4'd3, 1'b0);
    for (int k = 0; k < 16; k++) begin
      mem_ready = k[0];
      checks++;
      if (got_out() !== exp_out()) begin errors++; $display("FAIL wrap cyc=%0d got=%h want=%h", cyc, got_out(), exp_out()); end
      step();
      req_valid = '0;
    end
    checks++;
    if (beat_cyc.size() != 4 || done_cyc.size() != 1) begin
      errors++; $display("FAIL wrap_counts got beats=%0d dones=%0d want 4 1", beat_cyc.size(), done_cyc.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if ({beat_addr[k], beat_wen[k], beat_rid[k]} !== {exp_a[k], 1'b0, 1'b1}) begin
          errors++; $display("FAIL wrap_beat%0d got a=%0d w=%b r=%b want a=%0d w=0 r=1", k, beat_addr[k], beat_wen[k], beat_rid[k], exp_a[k]);
        end
      end
      checks++;
      if (done_val[0] !== 2'b10) begin errors++; $display("FAIL wrap_done got %b want 10", done_val[0]); end
    end
  endtask

  task automatic test_round_robin();
    int c;
    logic [AW-1:0] exp_a[8] = '{5'd0, 5'd1, 5'd16, 5'd18, 5'd8, 5'd9, 5'd24, 5'd26};
    int exp_c[8] = '{2, 3, 5, 6, 8, 9, 11, 12};
    clear_logs();
    c = cyc; mem_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      if (k == 0) begin set_req(0, 5'd0, 8'd2, 4'd1, 1'b1); set_req(1, 5'd16, 8'd2, 4'd2, 1'b0); end
      if (k == 1) begin set_req(0, 5'd8, 8'd2, 4'd1, 1'b1); set_req(1, 5'd24, 8'd2, 4'd2, 1'b0); end
      if (k == 2) begin
        checks++;
        if (req_ready !== 2'b01) begin errors++; $display("FAIL rr_ready got %b want 01", req_ready); end
      end
      checks++;
      if (got_out() !== exp_out()) begin errors++; $display("FAIL rr cyc=%0d got=%h want=%h", cyc, got_out(), exp_out()); end
      step();
      req_valid = '0;
    end
    checks++;
    if (beat_cyc.size() != 8 || done_cyc.size() != 4) begin
      errors++; $display("FAIL rr_counts got beats=%0d dones=%0d want 8 4", beat_cyc.size(), done_cyc.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (beat_rid[k] !== 1'((k / 2) % 2) || beat_addr[k] !== exp_a[k] || beat_cyc[k] != c + exp_c[k]) begin
          errors++; $display("FAIL rr_beat%0d got r=%b a=%0d cyc=c+%0d", k, beat_rid[k], beat_addr[k], beat_cyc[k] - c);
        end
      end
    end
  endtask

  task automatic test_zero_count();
    int c;
    clear_logs();
    c = cyc; mem_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (k == 0) set_req(0, 5'd3, 8'd0, 4'd1, 1'b1);
      if (k == 1) set_req(0, 5'd5, 8'd1, 4'd2, 1'b0);
      checks++;
      if (got_out() !== exp_out()) begin errors++; $display("FAIL zero cyc=%0d got=%h want=%h", cyc, got_out(), exp_out()); end
      step();
      req_valid = '0;
    end
    checks++;
    if (beat_cyc.size() != 1 || done_cyc.size() != 2) begin
      errors++; $display("FAIL zero_counts got beats=%0d dones=%0d want 1 2", beat_cyc.size(), done_cyc.size());
    end else begin
      checks++;
      if (beat_addr[0] !== 5'd5 || beat_cyc[0] != c + 3) begin
        errors++; $display("FAIL zero_beat got a=%0d cyc=c+%0d want 5 c+3", beat_addr[0], beat_cyc[0] - c);
      end
      checks++;
      if (done_cyc[0] != c + 2 || done_cyc[1] != c + 4 || done_val[0] !== 2'b01 || done_val[1] !== 2'b01) begin
        errors++; $display("FAIL zero_done got c+%0d/%b c+%0d/%b want c+2/01 c+4/01", done_cyc[0] - c, done_val[0], done_cyc[1] - c, done_val[1]);
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    int c;
    clear_logs();
    c = cyc; mem_ready = 1'b1;
    set_req(0, 5'd10, 8'd8, 4'd1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (got_out() !== exp_out()) begin errors++; $display("FAIL midrst cyc=%0d got=%h want=%h", cyc, got_out(), exp_out()); end
      step();
      req_valid = '0;
    end
    checks++;
    if (!mem_valid || mem_addr !== 5'd11) begin errors++; $display("FAIL midrst_beat2 got v=%b a=%0d want 1 11", mem_valid, mem_addr); end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({mem_valid, mem_wen, done, busy, req_ready, mem_addr} !== {1'b0, 1'b0, 2'b00, 1'b0, 2'b11, 5'd0}) begin
      errors++; $display("FAIL midrst_async got v=%b w=%b d=%b b=%b rdy=%b a=%0d", mem_valid, mem_wen, done, busy, req_ready, mem_addr);
    end
    model_reset();
    clear_logs();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    rst = 1'b1;
    c = cyc;
    set_req(0, 5'd2, 8'd1, 4'd1, 1'b1);
    set_req(1, 5'd20, 8'd1, 4'd1, 1'b0);
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (got_out() !== exp_out()) begin errors++; $display("FAIL postrst cyc=%0d got=%h want=%h", cyc, got_out(), exp_out()); end
      step();
      req_valid = '0;
    end
    checks++;
    if (beat_cyc.size() != 2 || done_cyc.size() != 2) begin
      errors++; $display("FAIL postrst_counts got beats=%0d dones=%0d want 2 2", beat_cyc.size(), done_cyc.size());
    end else if (beat_rid[0] !== 1'b0 || beat_addr[0] !== 5'd2 || beat_cyc[0] != c + 2 || beat_rid[1] !== 1'b1) begin
      errors++; $display("FAIL postrst_order got r0=%b a0=%0d cyc=c+%0d r1=%b", beat_rid[0], beat_addr[0], beat_cyc[0] - c, beat_rid[1]);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 1500; k++) begin
      req_valid = (k < 1400) ? 2'($urandom) : 2'b00;
      req_addr = 10'($urandom);
      req_stride = 8'($urandom);
      req_wen = 2'($urandom);
      req_count = {8'($urandom_range(0, 6)), 8'($urandom_range(0, 6))};
      mem_ready = (k >= 1400) || ($urandom_range(0, 3) != 0);
      checks++;
      if (got_out() !== exp_out()) begin errors++; $display("FAIL random cyc=%0d got=%h want=%h", cyc, got_out(), exp_out()); end
      step();
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL random_drain got busy=%b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_wrap_backpressure();
    test_round_robin();
    test_zero_count();
    test_reset_mid_burst();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
